// File: rtl/db_arbiter.sv
// ---------------------------------------------------------------------------
// db_arbiter
//
// Round-robin arbiter that shares one memory/IO data bus (db_*) among
// N_MASTERS requesters, for example the CPU fetch and data ports, DMA or a
// UART loader. Only one transaction is in flight at a time. The winner's
// request attributes are latched on the grant edge, so the slave sees stable
// values for the whole transaction. The granted master receives a one-cycle
// m_ready pulse, and all masters share the m_dataIn read-data return.
//
// Transaction flow: IDLE (arbitrate) -> BUSY (strobes up until db_ready)
// -> DONE (one cycle, m_ready pulse) -> IDLE.
//
// Parameters:
//   N_MASTERS      number of masters (1..8)
//   ADDR_W         address width
//   DATA_W         data width
//   TIMEOUT_CYCLES slave wait limit; only used with DB_ARB_TIMEOUT_EN
//
// Optional feature macro: DB_ARB_TIMEOUT_EN
//   When defined, a BUSY wait counter ends a stalled transaction after
//   TIMEOUT_CYCLES cycles. The transaction then completes with
//   m_dataIn = all ones and m_err = 1. When undefined, BUSY waits forever
//   and m_err is tied low.
//
// Ports:
//   clk, res_n            clock (rising edge), async active-low reset
//   m_re/m_we/m_io        per-master read/write request and IO qualifier
//   m_addr/m_dataOut      packed per-master address / write data
//   m_dataIn              shared read-data return
//   m_ready               one-cycle completion pulse to the owner
//   m_grant               one-hot current owner, zero when idle
//   m_err                 timeout flag, coincident with m_ready
//   db_dataIn/db_ready    slave read data / completion
//   db_dataOut/db_addr    slave write data / address
//   db_re/db_we/db_io     slave strobes and IO qualifier
// ---------------------------------------------------------------------------
module db_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        res_n,
    input  logic [N_MASTERS-1:0]        m_re,
    input  logic [N_MASTERS-1:0]        m_we,
    input  logic [N_MASTERS-1:0]        m_io,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS*DATA_W-1:0] m_dataOut,
    output logic [DATA_W-1:0]           m_dataIn,
    output logic [N_MASTERS-1:0]        m_ready,
    output logic [N_MASTERS-1:0]        m_grant,
    output logic                        m_err,
    input  logic [DATA_W-1:0]           db_dataIn,
    input  logic                        db_ready,
    output logic [DATA_W-1:0]           db_dataOut,
    output logic [ADDR_W-1:0]           db_addr,
    output logic                        db_re,
    output logic                        db_we,
    output logic                        db_io
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    // Reject configurations that this arbiter cannot support.
    if (N_MASTERS < 1 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("db_arbiter: N_MASTERS must be 1..8 and TIMEOUT_CYCLES 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last;
    logic                   wflag;

    logic [N_MASTERS-1:0]   req;
    logic                   found;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W:0]         scan;
    logic [N_MASTERS-1:0]   win_onehot;

    logic [ADDR_W-1:0]      addr_arr [N_MASTERS];
    logic [DATA_W-1:0]      data_arr [N_MASTERS];

`ifdef DB_ARB_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

    logic [CNT_W-1:0]       wait_cnt;
    logic                   err_q;
    logic                   at_limit;

    // This wait cycle is the one that brings the counter up to the limit.
    assign at_limit = (int'(wait_cnt) + 1) >= TIMEOUT_CYCLES;
    assign m_err    = err_q;
`else
    assign m_err = 1'b0;
`endif

    // Unpack the flat per-master buses so the winner can be selected by index.
    for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
        assign addr_arr[g] = m_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = m_dataOut[g*DATA_W +: DATA_W];
    end

    assign req = m_re | m_we;

    // Round-robin scan: last+1, last+2, ... wrapping at N_MASTERS. The first
    // active requester wins. last < N and k <= N, so one conditional
    // subtraction is enough for the wrap.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            scan = {1'b0, last} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(N_MASTERS)) begin
                scan = scan - (IDX_W+1)'(N_MASTERS);
            end
            if (!found && req[scan[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            win_onehot[i] = (winner == IDX_W'(i));
        end
    end

    // Main FSM. All bus-facing outputs are registered here. A write wins when
    // re and we are both set. m_ready mirrors m_grant for the single DONE
    // cycle. DONE never arbitrates, so a master still holding its request
    // there cannot be re-granted back to back.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= IDLE;
            last       <= IDX_W'(N_MASTERS - 1);
            wflag      <= 1'b0;
            m_dataIn   <= '0;
            m_ready    <= '0;
            m_grant    <= '0;
            db_dataOut <= '0;
            db_addr    <= '0;
            db_re      <= 1'b0;
            db_we      <= 1'b0;
            db_io      <= 1'b0;
`ifdef DB_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        db_addr    <= addr_arr[winner];
                        db_dataOut <= data_arr[winner];
                        db_io      <= m_io[winner];
                        wflag      <= m_we[winner];
                        db_we      <= m_we[winner];
                        db_re      <= ~m_we[winner];
                        m_grant    <= win_onehot;
                        last       <= winner;
`ifdef DB_ARB_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                        state      <= BUSY;
                    end
                end

                BUSY: begin
                    if (db_ready) begin
                        if (!wflag) begin
                            m_dataIn <= db_dataIn;
                        end
                        db_re   <= 1'b0;
                        db_we   <= 1'b0;
                        m_ready <= m_grant;
                        state   <= DONE;
                    end
`ifdef DB_ARB_TIMEOUT_EN
                    else if (at_limit) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        m_dataIn <= '1;
                        db_re    <= 1'b0;
                        db_we    <= 1'b0;
                        m_ready  <= m_grant;
                        err_q    <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    m_ready <= '0;
                    m_grant <= '0;
`ifdef DB_ARB_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_db_arbiter.sv
// ---------------------------------------------------------------------------
// tb_db_arbiter
//
// Testbench for db_arbiter with N_MASTERS = 2. A transaction-level reference
// model tracks the owner, the latched request, whether the strobes are up and
// whether the completion pulse is due. The bench compares every DUT output
// against that model after each clock. Directed scenarios add hand-computed
// literal checks, and a randomized phase follows with masters that hold their
// requests until served.
// ---------------------------------------------------------------------------
module tb_db_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic            clk;
    logic            res_n;
    logic [N-1:0]    m_re;
    logic [N-1:0]    m_we;
    logic [N-1:0]    m_io;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_dataOut;
    logic [DW-1:0]   m_dataIn;
    logic [N-1:0]    m_ready;
    logic [N-1:0]    m_grant;
    logic            m_err;
    logic [DW-1:0]   db_dataIn;
    logic            db_ready;
    logic [DW-1:0]   db_dataOut;
    logic [AW-1:0]   db_addr;
    logic            db_re;
    logic            db_we;
    logic            db_io;

    int tests_run;
    int tests_failed;

    // Reference model state
    int            owner;
    bit            strobes;
    bit            pulse;
    bit            mdl_write;
    bit            mdl_io;
    bit            mdl_err;
    int            last_srv;
    int            wait_n;
    logic [AW-1:0] mdl_addr;
    logic [DW-1:0] mdl_wdata;
    logic [DW-1:0] mdl_rdata;

    bit pend [N];

    db_arbiter #(
        .N_MASTERS      (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .m_re       (m_re),
        .m_we       (m_we),
        .m_io       (m_io),
        .m_addr     (m_addr),
        .m_dataOut  (m_dataOut),
        .m_dataIn   (m_dataIn),
        .m_ready    (m_ready),
        .m_grant    (m_grant),
        .m_err      (m_err),
        .db_dataIn  (db_dataIn),
        .db_ready   (db_ready),
        .db_dataOut (db_dataOut),
        .db_addr    (db_addr),
        .db_re      (db_re),
        .db_we      (db_we),
        .db_io      (db_io)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    function automatic void modelReset();
        owner     = -1;
        strobes   = 1'b0;
        pulse     = 1'b0;
        mdl_write = 1'b0;
        mdl_io    = 1'b0;
        mdl_err   = 1'b0;
        last_srv  = N - 1;
        wait_n    = 0;
        mdl_addr  = '0;
        mdl_wdata = '0;
        mdl_rdata = '0;
    endfunction

    // Advance the model by one clock, using the inputs the DUT will sample.
    function automatic void modelStep();
        bit got;
        got = 1'b0;
        if (pulse) begin
            pulse   = 1'b0;
            mdl_err = 1'b0;
            owner   = -1;
        end else if (owner >= 0) begin
            if (db_ready) begin
                if (!mdl_write) mdl_rdata = db_dataIn;
                strobes = 1'b0;
                pulse   = 1'b1;
            end
`ifdef DB_ARB_TIMEOUT_EN
            else begin
                wait_n++;
                if (wait_n >= TMO) begin
                    strobes   = 1'b0;
                    pulse     = 1'b1;
                    mdl_rdata = '1;
                    mdl_err   = 1'b1;
                end
            end
`endif
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (last_srv + k) % N;
                if (!got && (m_re[i] || m_we[i])) begin
                    got       = 1'b1;
                    owner     = i;
                    last_srv  = i;
                    mdl_addr  = m_addr[i*AW +: AW];
                    mdl_wdata = m_dataOut[i*DW +: DW];
                    mdl_io    = m_io[i];
                    mdl_write = m_we[i];
                    strobes   = 1'b1;
                    wait_n    = 0;
                end
            end
        end
    endfunction

    task automatic checkOutput();
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ready;
        exp_grant = '0;
        exp_ready = '0;
        if (owner >= 0) begin
            exp_grant[owner] = 1'b1;
            if (pulse) exp_ready[owner] = 1'b1;
        end
        check("m_grant",  m_grant,  exp_grant);
        check("m_ready",  m_ready,  exp_ready);
        check("db_re",    db_re,    strobes && !mdl_write);
        check("db_we",    db_we,    strobes && mdl_write);
        check("m_dataIn", m_dataIn, mdl_rdata);
        check("m_err",    m_err,    mdl_err);
        if (strobes) begin
            check("db_addr",    db_addr,    mdl_addr);
            check("db_dataOut", db_dataOut, mdl_wdata);
            check("db_io",      db_io,      mdl_io);
        end
    endtask

    // One clock with the current inputs, then compare against the model.
    task automatic applyStimulus();
        if (!res_n) modelReset();
        else        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic setMaster(input int i, input bit re, input bit we, input bit io,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_re[i]              = re;
        m_we[i]              = we;
        m_io[i]              = io;
        m_addr[i*AW +: AW]   = a;
        m_dataOut[i*DW +: DW] = d;
        pend[i]              = re || we;
    endtask

    task automatic sawReady();
        for (int i = 0; i < N; i++) begin
            if (m_ready[i]) begin
                m_re[i] = 1'b0;
                m_we[i] = 1'b0;
                pend[i] = 1'b0;
            end
        end
    endtask

    // Withdraw non-owner requests and let any open transaction complete.
    task automatic drain();
        db_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) begin
                if (i != owner) begin
                    m_re[i] = 1'b0;
                    m_we[i] = 1'b0;
                    pend[i] = 1'b0;
                end
            end
            applyStimulus();
            sawReady();
        end
    endtask

    // Main sequence: reset, directed scenarios, then randomized traffic.
    initial begin
        int g_own [8];
        int g_cyc [8];
        int ng;
        logic [N-1:0] prev_grant;

        tests_run    = 0;
        tests_failed = 0;
        res_n        = 1'b0;
        m_re         = '0;
        m_we         = '0;
        m_io         = '0;
        m_addr       = '0;
        m_dataOut    = '0;
        db_dataIn    = '0;
        db_ready     = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        modelReset();

        applyStimulus();
        applyStimulus();
        check("reset_grant",  m_grant,  2'b00);
        check("reset_db_re",  db_re,    1'b0);
        check("reset_dataIn", m_dataIn, 32'h0);
        res_n = 1'b1;

        // Master 0 read with a zero-wait slave
        db_ready  = 1'b1;
        db_dataIn = 32'h12345678;
        setMaster(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        applyStimulus();
        check("t1_db_re",   db_re,   1'b1);
        check("t1_db_addr", db_addr, 32'h40);
        check("t1_grant",   m_grant, 2'b01);
        applyStimulus();
        check("t1_ready",  m_ready,  2'b01);
        check("t1_dataIn", m_dataIn, 32'h12345678);
        sawReady();
        applyStimulus();
        check("t1_grant_clear", m_grant, 2'b00);

        // Master 1 IO write, slave ready after 3 wait cycles
        db_ready  = 1'b0;
        db_dataIn = 32'hDEADBEEF;
        setMaster(1, 1'b0, 1'b1, 1'b1, 32'h1000, 32'hCAFEBABE);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus();
            check("t2_db_we",    db_we,      1'b1);
            check("t2_db_io",    db_io,      1'b1);
            check("t2_db_addr",  db_addr,    32'h1000);
            check("t2_db_data",  db_dataOut, 32'hCAFEBABE);
            check("t2_no_ready", m_ready,    2'b00);
            if (k == 4) db_ready = 1'b1;
        end
        applyStimulus();
        check("t2_ready",   m_ready,  2'b10);
        check("t2_we_drop", db_we,    1'b0);
        check("t2_dataIn",  m_dataIn, 32'h12345678);
        sawReady();
        applyStimulus();

        // Both masters requesting continuously from reset
        res_n = 1'b0;
        applyStimulus();
        res_n = 1'b1;
        setMaster(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        setMaster(1, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        db_ready   = 1'b1;
        prev_grant = '0;
        ng         = 0;
        for (int c = 1; c <= 12; c++) begin
            applyStimulus();
            if (m_grant != 2'b00 && prev_grant == 2'b00 && ng < 8) begin
                g_own[ng] = m_grant[1] ? 1 : 0;
                g_cyc[ng] = c;
                ng++;
            end
            prev_grant = m_grant;
            check("t3_one_ready", ($countones(m_ready) <= 1), 1'b1);
        end
        check("t3_ngrants", ng, 4);
        check("t3_first_cycle", g_cyc[0], 1);
        for (int j = 0; j < 4; j++) begin
            check("t3_order", g_own[j], j % 2);
            if (j > 0) check("t3_spacing", g_cyc[j] - g_cyc[j-1], 3);
        end
        drain();

        // Reset pulse during a stalled transaction
        setMaster(0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
        db_ready = 1'b0;
        applyStimulus();
        applyStimulus();
        check("t4_busy", db_re, 1'b1);
        #2;
        res_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        check("t4_db_re",  db_re,   1'b0);
        check("t4_grant",  m_grant, 2'b00);
        check("t4_ready",  m_ready, 2'b00);
        applyStimulus();
        res_n = 1'b1;
        setMaster(1, 1'b1, 1'b0, 1'b0, 32'h304, 32'h0);
        db_ready = 1'b1;
        applyStimulus();
        check("t4_first_winner", m_grant, 2'b01);
        drain();

        // re and we both high: the request is a write
        setMaster(0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h55AA);
        db_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            applyStimulus();
            check("t6_db_we", db_we, 1'b1);
            check("t6_db_re", db_re, 1'b0);
        end
        db_ready = 1'b1;
        applyStimulus();
        check("t6_ready", m_ready, 2'b01);
        sawReady();
        drain();

        // Slave that never answers
        setMaster(0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        db_ready  = 1'b0;
        db_dataIn = 32'h0BADF00D;
`ifdef DB_ARB_TIMEOUT_EN
        for (int k = 0; k < TMO; k++) begin
            applyStimulus();
            check("t5_db_re", db_re, 1'b1);
        end
        applyStimulus();
        check("t5_ready",  m_ready,  2'b01);
        check("t5_err",    m_err,    1'b1);
        check("t5_dataIn", m_dataIn, 32'hFFFFFFFF);
        check("t5_re_drop", db_re,   1'b0);
        sawReady();
        drain();
`else
        for (int k = 0; k < 1000; k++) begin
            applyStimulus();
        end
        check("t5_still_busy", db_re,   1'b1);
        check("t5_no_ready",   m_ready, 2'b00);
        check("t5_grant",      m_grant, 2'b01);
        check("t5_no_err",     m_err,   1'b0);
        db_ready = 1'b1;
        applyStimulus();
        check("t5_ready",  m_ready,  2'b01);
        check("t5_dataIn", m_dataIn, 32'h0BADF00D);
        sawReady();
        drain();
`endif

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        int op;
                        op = int'($urandom_range(0, 2));
                        setMaster(i, op != 1, op != 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
                    end
                end else if (i != owner && $urandom_range(0, 19) == 0) begin
                    m_re[i] = 1'b0;
                    m_we[i] = 1'b0;
                    pend[i] = 1'b0;
                end
            end
            db_ready  = ($urandom_range(0, 2) != 0);
            db_dataIn = $urandom;
            applyStimulus();
            sawReady();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
